booth_mult_arbiter: RTL and testbench
=====================================

Name: booth_mult_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational 4x4 Booth multiplier instance among NREQ requesters. It captures the winning requester's operands into registers and drives them onto the shared multiplier. It then registers the 8-bit product and returns it with the requester ID over a valid/ready result port. The block sits between the requesting datapath units and the single multiplier instance, and keeps a completed-operation counter.

Parameters:
NREQ, 4, number of requesters; legal range 2..16.
CNTW, 16, width of the completed-operation counter.
IDW, $clog2(NREQ), localparam; width of requester ID.

Ports:
clk  input  1  rising-edge clock; single clock domain.
rst  input  1  synchronous, active-high reset.
req  input  NREQ  request per requester; level, held until that requester sees its gnt bit.
a_in  input  4*NREQ  operand a per requester; requester i uses bits [4i+3:4i]; signed two's complement.
b_in  input  4*NREQ  operand b per requester; same slicing; unsigned 0..15.
gnt  output  NREQ  one-hot, high for exactly one cycle (ISSUE); acknowledges operand capture.
mul_a  output  4  registered operand a to the shared multiplier.
mul_b  output  4  registered operand b to the shared multiplier.
mul_p  input  8  combinational product from the shared multiplier.
res_valid  output  1  result available.
res_ready  input  1  consumer accepts result.
res_p  output  8  registered product, signed; a*b range is -120..105.
res_id  output  IDW  index of the requester that owns res_p.
busy  output  1  high in ISSUE and RESP.
ops_cnt  output  CNTW  count of results accepted (res_valid && res_ready); wraps modulo 2^CNTW.

Behaviour:
- Reset (rst=1 at a clk edge) clears every output and all state to 0: state=IDLE, ptr=0, owner=0. Any in-flight operation or held result is discarded. Reset has priority over all other events.
- FSM states: IDLE, ISSUE, RESP.
- Arbitration runs in IDLE, and in RESP on a cycle where res_ready=1.
  - Winner = first i with req[i]=1, searching ptr, ptr+1, ... wrapping modulo NREQ.
  - If a winner exists, at the edge: gnt<=onehot(winner), mul_a/mul_b<=winner's operand slices, owner<=winner, state<=ISSUE.
  - If no request is pending: IDLE stays IDLE; RESP with res_ready=1 goes to IDLE.
- ISSUE (exactly 1 cycle):
  - gnt stays high and mul_a/mul_b stay stable; mul_p settles combinationally within the cycle.
  - At the edge: res_p<=mul_p, res_id<=owner, res_valid<=1, gnt<=0, ptr<=(owner+1) mod NREQ, state<=RESP.
  - req is ignored during ISSUE. A requester drops req after the edge at which it sees gnt high.
- RESP:
  - res_valid, res_p and res_id hold while res_ready=0. No new grant is issued. mul_a/mul_b hold their last values.
  - Edge with res_ready=1: ops_cnt increments. res_valid<=0 unless a new arbitration succeeds in the same cycle (back-to-back).
- Latency: acceptance edge (IDLE/RESP -> ISSUE) to res_valid=1 is 2 edges. Minimum issue interval is 2 cycles when res_ready is tied high.
- Arithmetic:
  - Operand a is signed 4-bit; operand b is unsigned 4-bit.
  - The block does not modify mul_p; it registers it verbatim.
  - b=0 must yield 0 for all a.
- Round-robin fairness: with all req held high, the grant order is 0,1,...,NREQ-1,0,... A requester waits at most NREQ-1 grants.
- Simultaneous events:
  - res_ready=1 and new req in RESP: the result is retired and the new grant is issued on the same edge.
  - A req that rises during ISSUE is considered at the next arbitration point.
- busy = (state != IDLE).

Test Plan:
- Single request: req=4'b0001, a_in[3:0]=4'b1000 (-8), b_in[3:0]=15, res_ready=1 → gnt=0001 for one cycle; 2 edges after acceptance res_valid=1, res_p=8'h88 (-120), res_id=0; ops_cnt=1.
- Round robin: req=4'b1111 held continuously, requester i has a=i, b=3, res_ready=1 → grant order 0,1,2,3,0. Results 0,3,6,9,0 are issued back-to-back with no IDLE cycle (res_valid remains high).
- Backpressure: with a result pending, hold res_ready=0 for 5 cycles while req=4'b0100 → res_valid, res_p and res_id are unchanged, gnt=0, ops_cnt does not change. When res_ready=1, gnt=0100 on the next cycle.
- Zero operand: a=-8, b=0 → res_p=0. Then a=7, b=15 → res_p=105 (8'h69).
- Reset mid-operation: assert rst during ISSUE → next cycle gnt=0, res_valid=0, res_p=0, res_id=0, busy=0, ops_cnt=0. The next request from requester 3 with req=4'b1001 is granted to 0 first, because ptr has been cleared to 0.
- Exhaustive: via requester 2, sweep a=-8..7 and b=0..15 (256 ops) → every res_p equals a*b as signed 8-bit, res_id=2, final ops_cnt=256.

Source files
------------

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one external combinational 4x4 Booth multiplier
// among NREQ requesters. Captures the winner's operands, registers the product and returns
// it with the owner ID over a valid/ready port. Also keeps a count of retired results.
module booth_mult_arbiter #(
    parameter int NREQ = 4,
    parameter int CNTW = 16,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] a_in,
    input  logic [4*NREQ-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [3:0]        mul_a,
    output logic [3:0]        mul_b,
    input  logic [7:0]        mul_p,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        res_p,
    output logic [IDW-1:0]    res_id,
    output logic              busy,
    output logic [CNTW-1:0]   ops_cnt
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    owner_q, owner_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [3:0]        mul_a_q, mul_a_d;
    logic [3:0]        mul_b_q, mul_b_d;
    logic [7:0]        res_p_q, res_p_d;
    logic [IDW-1:0]    res_id_q, res_id_d;
    logic              res_valid_q, res_valid_d;
    logic [CNTW-1:0]   ops_cnt_q, ops_cnt_d;

    logic              found;
    logic [IDW-1:0]    win;
    logic [IDW:0]      sum;

    // Round-robin search: first pending request starting at ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            if (!found && req[sum[IDW-1:0]]) begin
                found = 1'b1;
                win   = sum[IDW-1:0];
            end
        end
    end

    // Next-state logic: arbitration in IDLE and in RESP when the result is accepted.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        gnt_d       = '0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        res_p_d     = res_p_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;
        ops_cnt_d   = ops_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win;
                    mul_a_d = a_in[{win, 2'b00} +: 4];
                    mul_b_d = b_in[{win, 2'b00} +: 4];
                    owner_d = win;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                res_p_d     = mul_p;
                res_id_d    = owner_q;
                res_valid_d = 1'b1;
                ptr_d       = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + IDW'(1);
                state_d     = StResp;
            end
            StResp: begin
                if (res_ready) begin
                    ops_cnt_d = ops_cnt_q + CNTW'(1);
                    if (found) begin
                        // Back-to-back: old result stays visible until the new one lands.
                        gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win;
                        mul_a_d = a_in[{win, 2'b00} +: 4];
                        mul_b_d = b_in[{win, 2'b00} +: 4];
                        owner_d = win;
                        state_d = StIssue;
                    end else begin
                        res_valid_d = 1'b0;
                        state_d     = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset clearing everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            res_p_q     <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
            ops_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            res_p_q     <= res_p_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
            ops_cnt_q   <= ops_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign res_p     = res_p_q;
    assign res_id    = res_id_q;
    assign res_valid = res_valid_q;
    assign ops_cnt   = ops_cnt_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a behavioural stand-in for the shared multiplier.
module tb_booth_mult_arbiter;

    localparam int NREQ = 4;
    localparam int CNTW = 16;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] a_in;
    logic [4*NREQ-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic [3:0]        mul_a;
    logic [3:0]        mul_b;
    logic [7:0]        mul_p;
    logic              res_valid;
    logic              res_ready;
    logic [7:0]        res_p;
    logic [IDW-1:0]    res_id;
    logic              busy;
    logic [CNTW-1:0]   ops_cnt;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    // Shared multiplier: signed a times unsigned b.
    logic signed [8:0] prod9;
    assign prod9 = 9'($signed({{5{mul_a[3]}}, mul_a})) * $signed({5'b0, mul_b});
    assign mul_p = prod9[7:0];

    booth_mult_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_p     (res_p),
        .res_id    (res_id),
        .busy      (busy),
        .ops_cnt   (ops_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    // One operation from IDLE through retirement; res_ready held high.
    task automatic do_op(input int id, input int a, input int b, input string tag);
        logic [7:0] exp8;
        logic [3:0] a4;
        logic [3:0] b4;
        int         waited;
        a4 = 4'(a);
        b4 = 4'(b);
        exp8 = 8'(a * b);
        a_in[4*id +: 4] = a4;
        b_in[4*id +: 4] = b4;
        res_ready = 1'b1;
        req = 4'(1 << id);
        waited = 0;
        cycle();
        while (gnt == '0 && waited < 10) begin
            cycle();
            waited++;
        end
        check({tag, "_gnt"}, 32'(gnt), 32'(1 << id));
        req = '0;
        cycle();
        check({tag, "_valid"}, 32'(res_valid), 32'd1);
        check({tag, "_p"}, 32'(res_p), 32'(exp8));
        check({tag, "_id"}, 32'(res_id), 32'(id));
        cycle();
    endtask

    initial begin
        int cnt0;
        rst = 1'b1;
        req = '0;
        a_in = '0;
        b_in = '0;
        res_ready = 1'b0;
        do_reset();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(ops_cnt), 32'd0);
        check("rst_p", 32'(res_p), 32'd0);

        // Single request: -8 * 15 = -120.
        a_in[3:0] = 4'b1000;
        b_in[3:0] = 4'd15;
        res_ready = 1'b1;
        req = 4'b0001;
        cycle();
        check("single_gnt", 32'(gnt), 32'b0001);
        check("single_busy", 32'(busy), 32'd1);
        check("single_mula", 32'(mul_a), 32'h8);
        check("single_mulb", 32'(mul_b), 32'hf);
        check("single_valid_early", 32'(res_valid), 32'd0);
        req = 4'b0000;
        cycle();
        check("single_gnt_off", 32'(gnt), 32'd0);
        check("single_valid", 32'(res_valid), 32'd1);
        check("single_p", 32'(res_p), 32'h88);
        check("single_id", 32'(res_id), 32'd0);
        cycle();
        check("single_cnt", 32'(ops_cnt), 32'd1);
        check("single_idle_valid", 32'(res_valid), 32'd0);
        check("single_idle_busy", 32'(busy), 32'd0);

        // Round robin with all requests held; results i*3 back to back.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            a_in[4*i +: 4] = 4'(i);
            b_in[4*i +: 4] = 4'd3;
        end
        req = 4'b1111;
        res_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            cycle();
            check($sformatf("rr%0d_gnt", g), 32'(gnt), 32'(1 << (g % 4)));
            if (g > 0) check($sformatf("rr%0d_valid_hold", g), 32'(res_valid), 32'd1);
            if (g == 4) req = '0;
            cycle();
            check($sformatf("rr%0d_p", g), 32'(res_p), 32'((g % 4) * 3));
            check($sformatf("rr%0d_id", g), 32'(res_id), 32'(g % 4));
        end
        cycle();
        check("rr_cnt", 32'(ops_cnt), 32'd5);
        check("rr_idle", 32'(busy), 32'd0);

        // Backpressure: requester 1 result pending while requester 2 waits.
        a_in[7:4] = 4'(-3);
        b_in[7:4] = 4'd5;
        a_in[11:8] = 4'd3;
        b_in[11:8] = 4'd5;
        res_ready = 1'b0;
        req = 4'b0010;
        cycle();
        check("bp_gnt1", 32'(gnt), 32'b0010);
        req = 4'b0100;
        cycle();
        cnt0 = 5;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d_valid", c), 32'(res_valid), 32'd1);
            check($sformatf("bp%0d_p", c), 32'(res_p), 32'hf1);
            check($sformatf("bp%0d_id", c), 32'(res_id), 32'd1);
            check($sformatf("bp%0d_gnt", c), 32'(gnt), 32'd0);
            check($sformatf("bp%0d_cnt", c), 32'(ops_cnt), 32'(cnt0));
            cycle();
        end
        res_ready = 1'b1;
        cycle();
        check("bp_gnt2", 32'(gnt), 32'b0100);
        check("bp_cnt_after", 32'(ops_cnt), 32'd6);
        req = '0;
        cycle();
        check("bp_p2", 32'(res_p), 32'h0f);
        check("bp_id2", 32'(res_id), 32'd2);
        cycle();

        // Zero operand and maximum positive product.
        do_op(0, -8, 0, "zero");
        do_op(0, 7, 15, "max");

        // Reset during ISSUE clears state including the round-robin pointer.
        do_op(1, 2, 2, "pre_rst");
        a_in[11:8] = 4'd1;
        b_in[11:8] = 4'd1;
        req = 4'b0100;
        cycle();
        check("mid_gnt", 32'(gnt), 32'b0100);
        req = '0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_gnt0", 32'(gnt), 32'd0);
        check("mid_valid0", 32'(res_valid), 32'd0);
        check("mid_p0", 32'(res_p), 32'd0);
        check("mid_id0", 32'(res_id), 32'd0);
        check("mid_busy0", 32'(busy), 32'd0);
        check("mid_cnt0", 32'(ops_cnt), 32'd0);
        a_in[3:0] = 4'd2;
        b_in[3:0] = 4'd3;
        req = 4'b1001;
        cycle();
        check("mid_gnt_ptr0", 32'(gnt), 32'b0001);
        req = '0;
        cycle();
        check("mid_p", 32'(res_p), 32'd6);
        cycle();

        // Exhaustive sweep through requester 2.
        do_reset();
        for (int a = -8; a < 8; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(2, a, b, $sformatf("ex_a%0d_b%0d", a, b));
            end
        end
        check("ex_cnt", 32'(ops_cnt), 32'd256);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
